// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO multiply/divide sequencer with a one-bit-per-cycle signed engine.
// Define MULDIV_FORWARD_EN to forward the FIX-cycle result to MFHI/MFLO without stalling.
module muldiv_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             hlwrite,
   input  logic             multordiv,
   input  logic [1:0]       mvhl,
   input  logic             flush,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   output logic [WIDTH-1:0] hlout,
   output logic             stall,
   output logic             busy,
   output logic             divzero
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2;
   logic [1:0]         state;
   logic [CW-1:0]      counter;
   logic [WIDTH-1:0]   hi, lo, acc, q, ma, mb, abs_a, abs_b, fix_hi, fix_lo;
   logic [WIDTH:0]     sum, sh, dif;
   logic [2*WIDTH-1:0] prod;
   logic               sa, sb, op, start, rd, dz, fwd;
   always_comb begin
      abs_a   = srca[WIDTH-1] ? -srca : srca;
      abs_b   = srcb[WIDTH-1] ? -srcb : srcb;
      // acc is the running HI half (MULT) or partial remainder (DIV); q holds the other operand
      sum     = {1'b0, acc} + (q[0] ? {1'b0, ma} : '0);
      sh      = {acc, q[WIDTH-1]};
      dif     = sh - {1'b0, mb};
      prod    = (sa ^ sb) ? -{acc, q} : {acc, q};
      dz      = ~op & (mb == '0);
      fix_lo  = op ? prod[WIDTH-1:0] : dz ? '1 : (sa ^ sb) ? -q : q;
      fix_hi  = op ? prod[2*WIDTH-1:WIDTH] : dz ? (sa ? -ma : ma) : sa ? -acc : acc;
      busy    = state != IDLE;
      rd      = (mvhl == 2'b01) | (mvhl == 2'b10);
`ifdef MULDIV_FORWARD_EN
      fwd     = state == FIX;
      stall   = busy & (hlwrite | (rd & ~fwd));
`else
      fwd     = 1'b0;
      stall   = busy & (hlwrite | rd);
`endif
      hlout   = (mvhl == 2'b01) ? (fwd ? fix_lo : lo) : (mvhl == 2'b10) ? (fwd ? fix_hi : hi) : '0;
      divzero = (state == FIX) & dz;
      start   = (state == IDLE) & hlwrite & ~flush;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         counter <= '0;
         hi      <= '0;
         lo      <= '0;
         acc     <= '0;
         q       <= '0;
         ma      <= '0;
         mb      <= '0;
         sa      <= 1'b0;
         sb      <= 1'b0;
         op      <= 1'b0;
      end else if (start) begin
         ma      <= abs_a;
         mb      <= abs_b;
         sa      <= srca[WIDTH-1];
         sb      <= srcb[WIDTH-1];
         op      <= multordiv;
         acc     <= '0;
         q       <= multordiv ? abs_b : abs_a;
         counter <= CW'(WIDTH - 1);
         state   <= RUN;
      end else if (state == RUN) begin
         if (op) begin
            acc <= sum[WIDTH:1];
            q   <= {sum[0], q[WIDTH-1:1]};
         end else begin
            acc <= dif[WIDTH] ? sh[WIDTH-1:0] : dif[WIDTH-1:0];
            q   <= {q[WIDTH-2:0], ~dif[WIDTH]};
         end
         counter <= counter - 1'b1;
         if (counter == '0) state <= FIX;
      end else if (state == FIX) begin
         hi    <= fix_hi;
         lo    <= fix_lo;
         state <= IDLE;
      end
   end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: table vectors, timing sequences and randomized ops against an arithmetic model.
module tb_muldiv_ctrl;
   localparam int W = 32;
`ifdef MULDIV_FORWARD_EN
   localparam int EXP_LAST = 32;
`else
   localparam int EXP_LAST = 33;
`endif
   logic clk = 0, reset = 1, hlwrite = 0, multordiv = 0, flush = 0;
   logic [1:0] mvhl = 0;
   logic [W-1:0] srca = 0, srcb = 0, hlout;
   logic stall, busy, divzero;
   int tests = 0, fails = 0;
   typedef struct {
      logic op;
      logic [31:0] a, b, hi, lo;
      logic dz;
   } vec_t;
   vec_t vecs[7];

   always #5 clk = ~clk;

   muldiv_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .hlwrite(hlwrite), .multordiv(multordiv), .mvhl(mvhl),
      .flush(flush), .srca(srca), .srcb(srcb), .hlout(hlout), .stall(stall),
      .busy(busy), .divzero(divzero)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic model(input logic op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo, output logic dz);
      longint pa, pb, p, qq, rr;
      pa = longint'($signed(a));
      pb = longint'($signed(b));
      dz = 0;
      if (op) begin
         p = pa * pb;
         hi = p[63:32];
         lo = p[31:0];
      end else if (b == 0) begin
         dz = 1;
         lo = '1;
         hi = a;
      end else begin
         qq = pa / pb;
         rr = pa % pb;
         lo = qq[31:0];
         hi = rr[31:0];
      end
   endtask

   task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo,
                         output int busy_n, output int busy_first, output int dz_n, output int dz_at);
      hlwrite = 1; multordiv = op; srca = a; srcb = b;
      tick;
      hlwrite = 0; srca = $urandom; srcb = $urandom;
      busy_n = 0; busy_first = 0; dz_n = 0; dz_at = 0;
      for (int k = 1; k <= 40; k++) begin
         #3;
         if (busy) begin
            busy_n++;
            if (busy_first == 0) busy_first = k;
         end
         if (divzero) begin
            dz_n++;
            dz_at = k;
         end
         tick;
      end
      mvhl = 2'b10; #1 hi = hlout;
      mvhl = 2'b01; #1 lo = hlout;
      mvhl = 2'b00;
   endtask

   initial begin
      logic [31:0] hi, lo, ehi, elo, a, b;
      logic edz, op;
      int bn, bf, dn, da, first, last, got, acc_k, last_busy, sel;
      logic [31:0] drop_val;
      vecs[0] = '{1'b1, 32'h7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
      vecs[1] = '{1'b0, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
      vecs[2] = '{1'b0, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
      vecs[3] = '{1'b0, 32'h12345678, 32'h0,        32'h12345678, 32'hFFFFFFFF, 1'b1};
      vecs[4] = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0};
      vecs[5] = '{1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        1'b0};
      vecs[6] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h1,        1'b0};

      tick; tick;
      mvhl = 2'b01; #2;
      chk("reset_busy", busy, 0);
      chk("reset_stall", stall, 0);
      chk("reset_divzero", divzero, 0);
      chk("reset_lo", hlout, 0);
      mvhl = 2'b00;
      reset = 0;
      tick;

      for (int i = 0; i < 7; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, hi, lo, bn, bf, dn, da);
         chk($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
         chk($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
         chk($sformatf("vec%0d_busy_n", i), bn, 33);
         chk($sformatf("vec%0d_busy_first", i), bf, 1);
         chk($sformatf("vec%0d_dz_n", i), dn, vecs[i].dz ? 1 : 0);
         chk($sformatf("vec%0d_dz_at", i), da, vecs[i].dz ? 33 : 0);
      end

      // MFHI held behind a MULT
      hlwrite = 1; multordiv = 1; srca = 7; srcb = 32'hFFFFFFFD;
      tick;
      hlwrite = 0; mvhl = 2'b10;
      first = 0; last = 0; got = 0; drop_val = 0;
      for (int k = 1; k <= 40; k++) begin
         #3;
         if (stall) begin
            if (first == 0) first = k;
            last = k;
         end else if (got == 0 && first != 0) begin
            got = 1;
            drop_val = hlout;
         end
         tick;
      end
      chk("stall_first", first, 1);
      chk("stall_last", last, EXP_LAST);
      chk("stall_drop_hi", drop_val, 32'hFFFFFFFF);
      mvhl = 2'b01; #1;
      chk("mflo_val", hlout, 32'hFFFFFFEB);
      chk("mflo_stall", stall, 0);
      mvhl = 2'b00;

      // DIV presented right behind a MULT
      hlwrite = 1; multordiv = 1; srca = 3; srcb = 5;
      tick;
      multordiv = 0; srca = 100; srcb = 7;
      acc_k = 0; last_busy = 0; lo = 0; hi = 0;
      for (int k = 1; k <= 80; k++) begin
         if (k == 68) mvhl = 2'b01;
         if (k == 69) mvhl = 2'b10;
         #3;
         if (busy) last_busy = k;
         if (k == 68) lo = hlout;
         if (k == 69) hi = hlout;
         if (hlwrite && !stall && acc_k == 0) acc_k = k;
         tick;
         if (acc_k != 0) hlwrite = 0;
      end
      hlwrite = 0; mvhl = 2'b00;
      chk("b2b_accept", acc_k, 34);
      chk("b2b_last_busy", last_busy, 67);
      chk("b2b_lo", lo, 14);
      chk("b2b_hi", hi, 2);

      // flushed issue in IDLE is ignored
      hlwrite = 1; flush = 1; multordiv = 1; srca = 9; srcb = 9;
      tick;
      hlwrite = 0; flush = 0;
      #2;
      chk("flush_busy", busy, 0);
      tick;
      mvhl = 2'b01; #1;
      chk("flush_lo", hlout, 14);
      chk("flush_busy2", busy, 0);
      mvhl = 2'b00;

      // reset in the middle of a MULT
      hlwrite = 1; multordiv = 1; srca = 32'h1234; srcb = 32'h5678;
      tick;
      hlwrite = 0;
      repeat (9) tick;
      reset = 1;
      tick;
      reset = 0; mvhl = 2'b10; #2;
      chk("rst_busy", busy, 0);
      chk("rst_stall", stall, 0);
      chk("rst_divzero", divzero, 0);
      chk("rst_hi", hlout, 0);
      mvhl = 2'b01; #1;
      chk("rst_lo", hlout, 0);
      mvhl = 2'b00;
      run_op(1, 3, 4, hi, lo, bn, bf, dn, da);
      chk("post_rst_lo", lo, 12);
      chk("post_rst_hi", hi, 0);
      chk("post_rst_busy_n", bn, 33);

      for (int i = 0; i < 40; i++) begin
         op = 1'($urandom_range(0, 1));
         a = $urandom;
         b = $urandom;
         sel = $urandom_range(0, 7);
         if (sel == 0) b = 0;
         if (sel == 1) b = $urandom_range(0, 15) - 8;
         if (sel == 2) a = $urandom_range(0, 255) - 128;
         if (sel == 3) a = 32'h80000000;
         model(op, a, b, ehi, elo, edz);
         run_op(op, a, b, hi, lo, bn, bf, dn, da);
         chk($sformatf("rand%0d_hi(op=%0d a=%h b=%h)", i, op, a, b), hi, ehi);
         chk($sformatf("rand%0d_lo(op=%0d a=%h b=%h)", i, op, a, b), lo, elo);
         chk($sformatf("rand%0d_dz_at", i), da, edz ? 33 : 0);
         chk($sformatf("rand%0d_busy_n", i), bn, 33);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
